// File: rtl/ex_mem_stage_if.sv
// Bus bundle between the EX stage, the EX/MEM register and the data-memory side.
// The stage uses the slave modport; the environment driving it uses master.
interface ex_mem_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  localparam int NBYTES = XLEN / 8;

  logic               valid_i;
  logic               ready_o;
  logic               WB_i;
  logic [1:0]         Mem_i;
  logic               addr_mode_i;
  logic [1:0]         size_i;
  logic [XLEN-1:0]    ALUres_i;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    rs1_data_i;
  logic [XLEN-1:0]    rs2_data_i;
  logic [XLEN-1:0]    store_i;
  logic [RADDR_W-1:0] rd_addr_i;

  logic               valid_o;
  logic               ready_i;
  logic               WB_o;
  logic [1:0]         Mem_o;
  logic [RADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]    ALUres_o;
  logic [XLEN-1:0]    Memaddr_o;
  logic [XLEN-1:0]    Memdata_o;
  logic [NBYTES-1:0]  byteen_o;
  logic               misalign_o;

  modport master (
    output valid_i, WB_i, Mem_i, addr_mode_i, size_i, ALUres_i, imm_i,
           rs1_data_i, rs2_data_i, store_i, rd_addr_i, ready_i,
    input  ready_o, valid_o, WB_o, Mem_o, rd_addr_o, ALUres_o, Memaddr_o,
           Memdata_o, byteen_o, misalign_o
  );

  modport slave (
    input  valid_i, WB_i, Mem_i, addr_mode_i, size_i, ALUres_i, imm_i,
           rs1_data_i, rs2_data_i, store_i, rd_addr_i, ready_i,
    output ready_o, valid_o, WB_o, Mem_o, rd_addr_o, ALUres_o, Memaddr_o,
           Memdata_o, byteen_o, misalign_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a head/skid pair: computes the effective address,
// lane-aligns store data, builds byte enables and flags misaligned accesses.
module ex_mem_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  ex_mem_stage_if.slave  bus
);
  localparam int NBYTES = XLEN / 8;
  localparam int OFS_W  = $clog2(NBYTES);

  typedef struct packed {
    logic               wb;
    logic [1:0]         mem;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    data;
    logic [NBYTES-1:0]  be;
    logic               mis;
  } entry_t;

  logic [XLEN-1:0]   eff_addr;
  logic [OFS_W-1:0]  ofs;
  logic              is_mem;
  logic              size_bad;
  logic [2:0]        align_mask;
  logic              misalign;
  logic [NBYTES-1:0] lane_mask;
  entry_t            incoming;

  entry_t head_q;
  entry_t skid_q;
  logic   head_valid;
  logic   skid_valid;
  logic   ready_q;
  logic   accept;
  logic   retire;

  assign eff_addr = bus.rs1_data_i + (bus.addr_mode_i ? bus.rs2_data_i : bus.imm_i);
  assign ofs      = eff_addr[OFS_W-1:0];
  assign is_mem   = (bus.Mem_i == 2'b01) || (bus.Mem_i == 2'b10);

  // Sizes wider than the datapath are illegal; otherwise the low address bits
  // below the access size must be zero.
  always_comb begin
    align_mask = 3'((4'd1 << bus.size_i) - 4'd1);
    size_bad   = int'(bus.size_i) > OFS_W;
    misalign   = is_mem && (size_bad || (|(eff_addr[2:0] & align_mask)));
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      lane_mask[i] = (i < (1 << bus.size_i));
    end
  end

  always_comb begin
    incoming      = '0;
    incoming.rd   = bus.rd_addr_i;
    incoming.alu  = bus.ALUres_i;
    incoming.addr = eff_addr;
    incoming.mis  = misalign;
    incoming.wb   = misalign ? 1'b0 : bus.WB_i;
    incoming.mem  = (is_mem && !misalign) ? bus.Mem_i : 2'b00;
    incoming.be   = (is_mem && !misalign) ? (lane_mask << ofs) : '0;
    incoming.data = (bus.Mem_i == 2'b10 && !misalign) ? (bus.store_i << {ofs, 3'b000}) : '0;
  end

  assign accept = bus.valid_i && ready_q;
  assign retire = head_valid && bus.ready_i;

  // ready_q always tracks the skid slot being free after the coming edge, so
  // the upstream handshake never sees a combinational path from ready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else if (flush_i) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      ready_q <= !skid_valid;
      if (retire && skid_valid) begin
        head_q     <= skid_q;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (accept) begin
        if (!head_valid || retire) begin
          head_q     <= incoming;
          head_valid <= 1'b1;
          ready_q    <= 1'b1;
        end else begin
          skid_q     <= incoming;
          skid_valid <= 1'b1;
          ready_q    <= 1'b0;
        end
      end else if (retire) begin
        head_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.valid_o    = head_valid;
  assign bus.WB_o       = head_q.wb;
  assign bus.Mem_o      = head_q.mem;
  assign bus.rd_addr_o  = head_q.rd;
  assign bus.ALUres_o   = head_q.alu;
  assign bus.Memaddr_o  = head_q.addr;
  assign bus.Memdata_o  = head_q.data;
  assign bus.byteen_o   = head_q.be;
  assign bus.misalign_o = head_q.mis;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a 32-bit instance exercised with directed
// and random traffic, plus a 64-bit instance for double-word enables.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush64 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.XLEN(32), .RADDR_W(5)) ifc ();
  ex_mem_stage_if #(.XLEN(64), .RADDR_W(5)) ifc64 ();

  ex_mem_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ifc)
  );

  ex_mem_stage #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush64), .bus(ifc64)
  );

  typedef struct {
    logic        wb;
    logic [1:0]  mem;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the address/enable/data rules.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] ea;
    int          ofs;
    int          nb;
    logic        is_mem;
    ea     = ifc.rs1_data_i + (ifc.addr_mode_i ? ifc.rs2_data_i : ifc.imm_i);
    ofs    = int'(ea % 4);
    nb     = 1 << ifc.size_i;
    is_mem = (ifc.Mem_i == 2'd1) || (ifc.Mem_i == 2'd2);
    e.mis  = is_mem && (ifc.size_i == 2'd3 || (ea % nb) != 0);
    e.alu  = ifc.ALUres_i;
    e.addr = ea;
    e.rd   = ifc.rd_addr_i;
    e.wb   = e.mis ? 1'b0 : ifc.WB_i;
    e.mem  = (e.mis || ifc.Mem_i == 2'd3) ? 2'd0 : ifc.Mem_i;
    e.be   = (is_mem && !e.mis) ? 4'(((1 << nb) - 1) << ofs) : 4'd0;
    e.data = (ifc.Mem_i == 2'd2 && !e.mis) ? (ifc.store_i << (8 * ofs)) : 32'd0;
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic wb, input logic [1:0] mem,
                               input logic mode, input logic [1:0] size,
                               input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] rs2, input logic [31:0] st,
                               input logic [4:0] rd);
    ifc.valid_i     = v;
    ifc.WB_i        = wb;
    ifc.Mem_i       = mem;
    ifc.addr_mode_i = mode;
    ifc.size_i      = size;
    ifc.rs1_data_i  = rs1;
    ifc.imm_i       = imm;
    ifc.rs2_data_i  = rs2;
    ifc.store_i     = st;
    ifc.rd_addr_i   = rd;
    ifc.ALUres_i    = rs1 ^ 32'h5A5A_0000 ^ {27'd0, rd};
  endtask

  // One clock: sample handshakes at the negedge, score retires, log accepts.
  task automatic cycle();
    exp_t e;
    logic acc;
    logic ret;
    @(negedge clk);
    acc = ifc.valid_i && ifc.ready_o;
    ret = ifc.valid_o && ifc.ready_i;
    if (ret) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_retire", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_wb",   ifc.WB_o,       e.wb);
        checkOutput("sb_mem",  ifc.Mem_o,      e.mem);
        checkOutput("sb_rd",   ifc.rd_addr_o,  e.rd);
        checkOutput("sb_alu",  ifc.ALUres_o,   e.alu);
        checkOutput("sb_addr", ifc.Memaddr_o,  e.addr);
        checkOutput("sb_data", ifc.Memdata_o,  e.data);
        checkOutput("sb_be",   ifc.byteen_o,   e.be);
        checkOutput("sb_mis",  ifc.misalign_o, e.mis);
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ifc.valid_i = 1'b0;
    ifc.ready_i = 1'b1;
    for (int i = 0; i < 20 && (sb.size() > 0 || ifc.valid_o); i++) cycle();
    checkOutput("drain_empty", sb.size(), 0);
    checkOutput("drain_valid", ifc.valid_o, 0);
  endtask

  initial begin
    ifc.ready_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifc64.valid_i = 1'b0; ifc64.WB_i = 1'b0; ifc64.Mem_i = 2'd0;
    ifc64.addr_mode_i = 1'b0; ifc64.size_i = 2'd0; ifc64.ALUres_i = '0;
    ifc64.imm_i = '0; ifc64.rs1_data_i = '0; ifc64.rs2_data_i = '0;
    ifc64.store_i = '0; ifc64.rd_addr_i = '0; ifc64.ready_i = 1'b1;

    #2;
    checkOutput("rst_valid", ifc.valid_o, 0);
    checkOutput("rst_ready", ifc.ready_o, 0);
    checkOutput("rst_addr",  ifc.Memaddr_o, 0);
    checkOutput("rst_be",    ifc.byteen_o, 0);
    checkOutput("rst_mis",   ifc.misalign_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("ready_before_edge", ifc.ready_o, 0);
    cycle();
    checkOutput("ready_after_reset", ifc.ready_o, 1);

    $display("[TB] streaming load and byte store");
    ifc.ready_i = 1'b1;
    applyStimulus(1, 1, 2'd1, 0, 2'd2, 32'h1000, 32'h24, 0, 0, 5'd3);
    cycle();
    checkOutput("t1_valid", ifc.valid_o, 1);
    checkOutput("t1_addr",  ifc.Memaddr_o, 32'h1024);
    checkOutput("t1_be",    ifc.byteen_o, 4'b1111);
    checkOutput("t1_mis",   ifc.misalign_o, 0);
    applyStimulus(1, 0, 2'd2, 1, 2'd0, 32'h2000, 0, 32'h3, 32'hAB, 5'd0);
    cycle();
    checkOutput("t2_addr", ifc.Memaddr_o, 32'h2003);
    checkOutput("t2_be",   ifc.byteen_o, 4'b1000);
    checkOutput("t2_data", ifc.Memdata_o, 32'hAB00_0000);
    drain();

    $display("[TB] back-pressure A B C");
    ifc.ready_i = 1'b0;
    applyStimulus(1, 1, 2'd1, 0, 2'd2, 32'hA000, 32'h0, 0, 0, 5'd10);
    cycle();
    applyStimulus(1, 1, 2'd1, 0, 2'd2, 32'hB000, 32'h4, 0, 0, 5'd11);
    cycle();
    checkOutput("bp_ready_low", ifc.ready_o, 0);
    checkOutput("bp_head_is_a", ifc.rd_addr_o, 5'd10);
    applyStimulus(1, 1, 2'd2, 0, 2'd1, 32'hC000, 32'h2, 0, 32'h1234, 5'd12);
    cycle();
    checkOutput("bp_hold_head", ifc.Memaddr_o, 32'hA000);
    checkOutput("bp_depth", sb.size(), 2);
    ifc.ready_i = 1'b1;
    cycle();
    cycle();
    ifc.valid_i = 1'b0;
    drain();

    $display("[TB] misaligned, wrap-around and odd ops");
    applyStimulus(1, 1, 2'd1, 0, 2'd1, 32'h1001, 0, 0, 0, 5'd7);
    cycle();
    checkOutput("t4_mis",  ifc.misalign_o, 1);
    checkOutput("t4_mem",  ifc.Mem_o, 2'd0);
    checkOutput("t4_wb",   ifc.WB_o, 0);
    checkOutput("t4_addr", ifc.Memaddr_o, 32'h1001);
    applyStimulus(1, 1, 2'd1, 0, 2'd2, 32'hFFFF_FFFC, 32'h8, 0, 0, 5'd8);
    cycle();
    checkOutput("t5_wrap", ifc.Memaddr_o, 32'h0000_0004);
    applyStimulus(1, 1, 2'd3, 0, 2'd0, 32'h40, 32'h1, 0, 32'hFF, 5'd9);
    cycle();
    checkOutput("op11_mem", ifc.Mem_o, 2'd0);
    checkOutput("op11_be",  ifc.byteen_o, 4'd0);
    applyStimulus(1, 0, 2'd2, 0, 2'd1, 32'h200, 32'h2, 0, 32'hBEEF, 5'd1);
    cycle();
    checkOutput("sh_data", ifc.Memdata_o, 32'hBEEF_0000);
    checkOutput("sh_be",   ifc.byteen_o, 4'b1100);
    applyStimulus(1, 0, 2'd2, 0, 2'd3, 32'h300, 32'h0, 0, 32'h1, 5'd2);
    cycle();
    checkOutput("dw_illegal", ifc.misalign_o, 1);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom),
                    1'($urandom), 2'($urandom),
                    {$urandom} & 32'hFFFF_FFF8, 32'($urandom_range(0, 7)),
                    32'($urandom_range(0, 7)), $urandom, 5'($urandom));
      ifc.ready_i = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("[TB] flush at occupancy 2");
    ifc.ready_i = 1'b0;
    applyStimulus(1, 1, 2'd1, 0, 2'd2, 32'h500, 0, 0, 0, 5'd4);
    cycle();
    cycle();
    checkOutput("fl_full", ifc.ready_o, 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checkOutput("fl_valid", ifc.valid_o, 0);
    checkOutput("fl_ready", ifc.ready_o, 1);
    ifc.valid_i = 1'b0;
    cycle();
    checkOutput("fl_stays_empty", ifc.valid_o, 0);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1, 1, 2'd2, 0, 2'd2, 32'h600, 0, 0, 32'h77, 5'd5);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", ifc.valid_o, 0);
    checkOutput("ar_ready", ifc.ready_o, 0);
    checkOutput("ar_addr",  ifc.Memaddr_o, 0);
    checkOutput("ar_data",  ifc.Memdata_o, 0);
    checkOutput("ar_be",    ifc.byteen_o, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.valid_i = 1'b0;
    cycle();
    checkOutput("ar_ready_back", ifc.ready_o, 1);
    checkOutput("ar_still_empty", ifc.valid_o, 0);

    $display("[TB] 64-bit double word");
    ifc64.valid_i = 1'b1; ifc64.Mem_i = 2'd1; ifc64.size_i = 2'd3;
    ifc64.rs1_data_i = 64'h100; ifc64.imm_i = 64'h8;
    @(posedge clk); #1;
    ifc64.rs1_data_i = 64'h104;
    checkOutput("x64_be",   ifc64.byteen_o, 8'hFF);
    checkOutput("x64_mis",  ifc64.misalign_o, 0);
    checkOutput("x64_addr", ifc64.Memaddr_o, 64'h108);
    @(posedge clk); #1;
    ifc64.valid_i = 1'b0;
    checkOutput("x64_mis_ofs4", ifc64.misalign_o, 1);
    checkOutput("x64_be_ofs4",  ifc64.byteen_o, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
